// File: rtl/clk_diag_multi.sv
// clk_diag_multi: multi-channel diagnostic LED driver.
// A shared prescaler produces a one-cycle tick. Each channel drives one output
// as OFF, ON, BLINK (toggle per tick) or CODE (a gap followed by N flashes).
// Optional feature: define CLK_DIAG_DIM_EN to add an 8-bit dim input and a
// free-running PWM counter that gates every output.
module clk_diag_multi #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned BITS      = 26,
   parameter int unsigned PERIOD    = 12288000,
   parameter int unsigned GAP_TICKS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BITS-1:0]       period,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [4*CHANNELS-1:0] code,
`ifdef CLK_DIAG_DIM_EN
   input  logic [7:0]            dim,
`endif
   output logic                  tick,
   output logic [CHANNELS-1:0]   out
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_CODE  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_GAP       = 2'd0,
      ST_FLASH_ON  = 2'd1,
      ST_FLASH_OFF = 2'd2
   } state_e;

   localparam logic [3:0] GAP_LAST = 4'(GAP_TICKS);

   logic [BITS-1:0]     count_q, count_d;
   logic                tick_q, tick_d;

   mode_e               mode_q  [CHANNELS];
   state_e              state_q [CHANNELS];
   logic [3:0]          gap_q   [CHANNELS];
   logic [3:0]          rem_q   [CHANNELS];
   logic [CHANNELS-1:0] lvl_q;

   // Next prescaler value: count down, reload with period-1 on expiry (0 and 1 both reload 0).
   always_comb begin
      count_d = count_q - BITS'(1);
      tick_d  = 1'b0;
      if (count_q == '0) begin
         tick_d  = 1'b1;
         count_d = (period <= BITS'(1)) ? '0 : period - BITS'(1);
      end
   end

   // Prescaler state and registered tick pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= BITS'(PERIOD);
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   // Per-channel mode register, CODE FSM and pattern level; a mode change overrides a coincident tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            mode_q[ch]  <= MODE_OFF;
            state_q[ch] <= ST_GAP;
            gap_q[ch]   <= '0;
            rem_q[ch]   <= '0;
         end
         lvl_q <= '0;
      end else begin
         for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (mode[2*ch +: 2] != mode_q[ch]) begin
               mode_q[ch]  <= mode_e'(mode[2*ch +: 2]);
               state_q[ch] <= ST_GAP;
               gap_q[ch]   <= '0;
               rem_q[ch]   <= '0;
               lvl_q[ch]   <= 1'b0;
            end else begin
               case (mode_q[ch])
                  MODE_OFF:   lvl_q[ch] <= 1'b0;
                  MODE_ON:    lvl_q[ch] <= 1'b1;
                  MODE_BLINK: if (tick_q) lvl_q[ch] <= ~lvl_q[ch];
                  MODE_CODE: begin
                     if (tick_q) begin
                        case (state_q[ch])
                           ST_GAP: begin
                              lvl_q[ch] <= 1'b0;
                              if (gap_q[ch] + 4'd1 == GAP_LAST) begin
                                 gap_q[ch] <= '0;
                                 rem_q[ch] <= code[4*ch +: 4];
                                 if (code[4*ch +: 4] != 4'd0) begin
                                    state_q[ch] <= ST_FLASH_ON;
                                    lvl_q[ch]   <= 1'b1;
                                 end
                              end else begin
                                 gap_q[ch] <= gap_q[ch] + 4'd1;
                              end
                           end
                           ST_FLASH_ON: begin
                              lvl_q[ch]   <= 1'b0;
                              rem_q[ch]   <= rem_q[ch] - 4'd1;
                              state_q[ch] <= ST_FLASH_OFF;
                           end
                           ST_FLASH_OFF: begin
                              if (rem_q[ch] == 4'd0) begin
                                 state_q[ch] <= ST_GAP;
                                 gap_q[ch]   <= '0;
                                 lvl_q[ch]   <= 1'b0;
                              end else begin
                                 state_q[ch] <= ST_FLASH_ON;
                                 lvl_q[ch]   <= 1'b1;
                              end
                           end
                           default: begin
                              state_q[ch] <= ST_GAP;
                              gap_q[ch]   <= '0;
                              lvl_q[ch]   <= 1'b0;
                           end
                        endcase
                     end
                  end
                  default: lvl_q[ch] <= 1'b0;
               endcase
            end
         end
      end
   end

   assign tick = tick_q;

`ifdef CLK_DIAG_DIM_EN
   logic [7:0] pwm_q;

   // Free-running PWM counter for output dimming.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pwm_q <= '0;
      else        pwm_q <= pwm_q + 8'd1;
   end

   assign out = lvl_q & {CHANNELS{pwm_q < dim}};
`else
   assign out = lvl_q;
`endif

endmodule

// File: tb/tb_clk_diag_multi.sv
// Directed testbench for clk_diag_multi (CHANNELS=2, PERIOD=4, GAP_TICKS=2).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_clk_diag_multi;

   localparam int unsigned CH = 2;
   localparam int unsigned BW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [BW-1:0] period;
   logic [2*CH-1:0] mode;
   logic [4*CH-1:0] code;
`ifdef CLK_DIAG_DIM_EN
   logic [7:0]    dim;
`endif
   logic          tick;
   logic [CH-1:0] out;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   int pat3  [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
   int seq20 [6] = '{0, 1, 0, 0, 0, 0};

   always #5 clk = ~clk;

   clk_diag_multi #(
      .CHANNELS (CH),
      .BITS     (BW),
      .PERIOD   (4),
      .GAP_TICKS(2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .period (period),
      .mode   (mode),
      .code   (code),
`ifdef CLK_DIAG_DIM_EN
      .dim    (dim),
`endif
      .tick   (tick),
      .out    (out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance until tick is visible; bounded.
   task automatic wait_tick();
      int unsigned n = 0;
      do begin
         step(1);
         n++;
      end while (tick !== 1'b1 && n < 20);
      if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 32'd1);
   endtask

   // Advance to the edge at which channels consume the next tick.
   task automatic tick_step();
      wait_tick();
      step(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      period = 8'd4;
      mode   = '0;
      code   = '0;
`ifdef CLK_DIAG_DIM_EN
      dim    = 8'd255;
`endif
      step(3);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_out", 32'(out), 32'd0);

      // Prescaler from reset: 4,3,2,1,0 then tick; then every 4 cycles.
      reset = 1'b1;
      step(4); chk("first_tick_early", 32'(tick), 32'd0);
      step(1); chk("first_tick", 32'(tick), 32'd1);
      step(3); chk("tick_gap", 32'(tick), 32'd0);
      step(1); chk("second_tick", 32'(tick), 32'd1);
      chk("idle_out", 32'(out), 32'd0);

      // ch0 BLINK, ch1 ON, changed while tick is visible.
      mode = {2'd1, 2'd2};
      step(1); chk("mode_restart", 32'(out), 32'd0);
      step(1); chk("on_out", 32'(out), 32'b10);
      step(2); chk("tick_e13", 32'(tick), 32'd1);
      chk("blink_pre", 32'(out), 32'b10);
      step(1); chk("blink_first", 32'(out), 32'b11);
      for (int k = 1; k <= 4; k++) begin
         step(4);
         chk("blink_cycle", 32'(out), ((k % 2) == 1) ? 32'b10 : 32'b11);
      end

      // ch0 CODE with code=3, ch1 OFF.
      mode = {2'd0, 2'd3};
      code = {4'd0, 4'd3};
      step(1); chk("code_restart", 32'(out), 32'd0);
      for (int t = 0; t < 16; t++) begin
         tick_step();
         chk("code3", 32'(out), 32'(pat3[t % 8]));
      end

      // code=0 stays dark; then code=2 flashes, and a mid-flash code change is ignored.
      code = '0;
      for (int t = 0; t < 8; t++) begin
         tick_step();
         chk("code0", 32'(out), 32'd0);
      end
      code = {4'd0, 4'd2};
      tick_step(); chk("code2_gap", 32'(out), 32'd0);
      tick_step(); chk("code2_flash", 32'(out), 32'd1);
      code = '0;
      for (int t = 0; t < 6; t++) begin
         tick_step();
         chk("code_latched", 32'(out), 32'(seq20[t]));
      end

      // Mode change coincident with tick while in FLASH_ON.
      code = {4'd0, 4'd3};
      tick_step(); chk("pre_flash_gap", 32'(out), 32'd0);
      tick_step(); chk("flash_on", 32'(out), 32'd1);
      wait_tick();
      mode = {2'd1, 2'd2};
      step(1); chk("prio_restart", 32'(out), 32'd0);
      step(1); chk("prio_hold", 32'(out), 32'b10);
      tick_step(); chk("prio_toggle", 32'(out), 32'b11);

      // Asynchronous reset mid-pattern, no clock edge in between.
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_out", 32'(out), 32'd0);
      chk("async_rst_tick", 32'(tick), 32'd0);

      // Period change applies only from the next reload.
      step(1);
      mode   = '0;
      code   = '0;
      period = 8'd4;
      reset  = 1'b1;
      step(1); period = 8'd1;
      step(3); chk("countdown_kept", 32'(tick), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("fast_tick", 32'(tick), 32'd1);
      end
      period = 8'd0;
      step(1); chk("period0_a", 32'(tick), 32'd1);
      step(1); chk("period0_b", 32'(tick), 32'd1);
      period = 8'd4;
      step(1); chk("reload_edge", 32'(tick), 32'd1);
      step(1); chk("reload_p4_a", 32'(tick), 32'd0);
      step(2); chk("reload_p4_b", 32'(tick), 32'd0);
      step(1); chk("reload_p4_tick", 32'(tick), 32'd1);

`ifdef CLK_DIAG_DIM_EN
      begin
         int unsigned hi = 0;
         mode = {2'd0, 2'd1};
         dim  = 8'd64;
         step(2);
         for (int i = 0; i < 256; i++) begin
            if (out[0]) hi++;
            step(1);
         end
         chk("dim_duty", hi, 32'd64);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
